// File: rtl/rs232out_arbiter.sv
// rtl/rs232out_arbiter.sv - round-robin byte arbiter sharing one RS-232 transmitter through a FIFO
// Optional line lock: define RS232_ARB_LINE_LOCK_EN to keep a requester granted until its 8'h0A.
module rs232out_arbiter #(
  parameter int NREQ      = 4,
  parameter int FIFO_LOG2 = 4
) (
  input  logic                    clk25MHz,
  input  logic                    reset_n,
  input  logic [8*NREQ-1:0]       req_data,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ack,
  output logic [7:0]              tx_data,
  output logic                    tx_we,
  input  logic                    tx_busy,
  output logic [FIFO_LOG2:0]      fifo_level,
  output logic [$clog2(NREQ)-1:0] grant_last
);

  localparam int PW    = $clog2(NREQ);
  localparam int LW    = FIFO_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_LOG2;

  typedef enum logic {S_IDLE, S_ISSUE} drain_state_t;

  drain_state_t         state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_we_q, tx_we_d;
  logic [7:0]           mem_q [DEPTH];

  logic                 fifo_full, fifo_empty;
  logic [NREQ-1:0]      eligible;
  logic [NREQ-1:0]      ack_oh;
  logic                 win_found;
  logic [PW-1:0]        win_idx;
  logic [7:0]           win_data;
  logic                 push, pop;
  int                   cand;

`ifdef RS232_ARB_LINE_LOCK_EN
  logic                 lock_q, lock_d;
  logic [PW-1:0]        lock_idx_q, lock_idx_d;
`endif

  assign fifo_full  = (level_q == LW'(DEPTH));
  assign fifo_empty = (level_q == '0);

  // Round-robin winner search starting just after the last granted requester
  always_comb begin
    eligible  = fifo_full ? '0 : req_valid;
`ifdef RS232_ARB_LINE_LOCK_EN
    if (lock_q) begin
      eligible = eligible & (NREQ'(1) << lock_idx_q);
    end
`endif
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(ptr_q) + off) % NREQ;
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
      end
    end
    ack_oh = '0;
    if (win_found) begin
      ack_oh[win_idx] = 1'b1;
    end
    win_data = req_data[8*int'(win_idx) +: 8];
    push     = win_found;
    ptr_d    = win_found ? win_idx : ptr_q;
  end

  // Acks are forced low while reset is held so no requester drops a byte
  assign req_ack = reset_n ? ack_oh : '0;

`ifdef RS232_ARB_LINE_LOCK_EN
  // Line lock: stay on the granted requester until it hands over a newline
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (push) begin
      lock_d     = (win_data != 8'h0A);
      lock_idx_d = win_idx;
    end
  end

  // Line lock state register
  always_ff @(posedge clk25MHz or negedge reset_n) begin
    if (!reset_n) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`else
`endif

  // Drain sequencer: issue one byte only when the transmitter is idle and no pulse is in flight
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !tx_busy && !tx_we_q) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    tx_we_d = (state_d == S_ISSUE);
  end

  // FIFO pointer and occupancy bookkeeping; pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q + FIFO_LOG2'(push);
    rd_ptr_d = rd_ptr_q + FIFO_LOG2'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  // FIFO storage needs no reset; occupancy decides what is valid
  always_ff @(posedge clk25MHz) begin
    if (push) begin
      mem_q[wr_ptr_q] <= win_data;
    end
  end

  // Control state register
  always_ff @(posedge clk25MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= PW'(NREQ - 1);
      level_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tx_data_q <= '0;
      tx_we_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      level_q   <= level_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tx_data_q <= tx_data_d;
      tx_we_q   <= tx_we_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_we      = tx_we_q;
  assign fifo_level = level_q;
  assign grant_last = ptr_q;

endmodule

// File: tb/tb_rs232out_arbiter.sv
// tb/tb_rs232out_arbiter.sv - scoreboard bench for rs232out_arbiter
module tb_rs232out_arbiter;

  localparam int NREQ  = 4;
  localparam int DEPTH = 16;

  logic              clk25MHz;
  logic              reset_n;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ack;
  logic [7:0]        tx_data;
  logic              tx_we;
  logic              tx_busy;
  logic [4:0]        fifo_level;
  logic [1:0]        grant_last;

  rs232out_arbiter #(.NREQ(NREQ), .FIFO_LOG2(4)) dut (
    .clk25MHz  (clk25MHz),
    .reset_n   (reset_n),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ack   (req_ack),
    .tx_data   (tx_data),
    .tx_we     (tx_we),
    .tx_busy   (tx_busy),
    .fifo_level(fifo_level),
    .grant_last(grant_last)
  );

  initial clk25MHz = 1'b0;
  always #20 clk25MHz = ~clk25MHz;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // requester byte sources
  logic [7:0] src_mem [NREQ][64];
  int         src_rd [NREQ];
  int         src_wr [NREQ];

  task automatic load(input int i, input logic [7:0] b);
    src_mem[i][src_wr[i]] = b;
    src_wr[i]++;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NREQ; i++) begin
      src_rd[i] = 0;
      src_wr[i] = 0;
    end
  endtask

  // scoreboard / reference state
  logic [7:0]      exp_q [$];
  int              ack_log [$];
  int              m_ptr;
  logic            m_we;
  logic [7:0]      m_data;
  logic            m_lock;
  int              m_lock_idx;
  logic [NREQ-1:0] acked;
  logic            prev_we;
  logic            we_seen;
  int              we_count;
  int              busy_mode;
  int              busy_cnt;

  // monitor: compare DUT against the reference, then advance the reference for this edge
  always @(negedge clk25MHz) begin
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] exp_ack;
    int              win;
    int              c;
    logic            pop;
    if (!reset_n) begin
      chk("rst_ack", req_ack, 0);
      chk("rst_we", tx_we, 0);
      chk("rst_level", fifo_level, 0);
      exp_q.delete();
      m_ptr = NREQ - 1; m_we = 0; m_lock = 0; m_lock_idx = 0;
      acked = '0; prev_we = 0; we_seen = 0;
    end else begin
      elig = (exp_q.size() < DEPTH) ? req_valid : '0;
`ifdef RS232_ARB_LINE_LOCK_EN
      if (m_lock) elig = elig & (NREQ'(1) << m_lock_idx);
`endif
      win = -1;
      for (int off = 1; off <= NREQ; off++) begin
        c = (m_ptr + off) % NREQ;
        if (win < 0 && elig[c]) win = c;
      end
      exp_ack = '0;
      if (win >= 0) exp_ack[win] = 1'b1;
      chk("req_ack", req_ack, exp_ack);
      chk("grant_last", grant_last, m_ptr);
      chk("fifo_level", fifo_level, exp_q.size());
      chk("tx_we", tx_we, m_we);
      if (m_we) chk("tx_data", tx_data, m_data);
      if (tx_we) chk("we_while_busy", tx_busy, 0);
      if (tx_we) chk("we_back_to_back", prev_we, 0);
      prev_we = tx_we;
      we_seen = tx_we;
      if (tx_we) we_count++;
      pop = !m_we && (exp_q.size() > 0) && !tx_busy;
      if (pop) m_data = exp_q.pop_front();
      m_we = pop;
      if (win >= 0) begin
        exp_q.push_back(req_data[8*win +: 8]);
        m_ptr = win;
        ack_log.push_back(win);
        m_lock     = (req_data[8*win +: 8] != 8'h0A);
        m_lock_idx = win;
      end
      acked = req_ack;
    end
  end

  // requester and transmitter models, driven just after each rising edge
  always @(posedge clk25MHz) begin
    #1;
    for (int i = 0; i < NREQ; i++) if (acked[i]) src_rd[i]++;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]     = (src_rd[i] < src_wr[i]);
      req_data[8*i +: 8] = req_valid[i] ? src_mem[i][src_rd[i]] : 8'h00;
    end
    if (!reset_n)      busy_cnt = 0;
    else if (we_seen)  busy_cnt = 10;
    else if (busy_cnt > 0) busy_cnt--;
    case (busy_mode)
      0:       tx_busy = 1'b0;
      1:       tx_busy = 1'b1;
      default: tx_busy = (busy_cnt > 0);
    endcase
  end

  function automatic logic is_idle();
    logic e;
    e = (exp_q.size() == 0) && !m_we;
    for (int i = 0; i < NREQ; i++) if (src_rd[i] < src_wr[i]) e = 1'b0;
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk25MHz);
      #2;
    end
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (!is_idle() && n < bound) begin
      step(1);
      n++;
    end
    chk(tag, is_idle(), 1);
    step(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int k;
    reset_n = 1'b0; req_valid = '0; req_data = '0; tx_busy = 1'b0;
    busy_mode = 0; busy_cnt = 0; we_count = 0; acked = '0;
    m_ptr = NREQ - 1; m_we = 0; m_lock = 0; m_lock_idx = 0; prev_we = 0; we_seen = 0;
    clear_srcs();
    step(3);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant_last", grant_last, NREQ - 1);
    @(negedge clk25MHz); #5 reset_n = 1'b1;
    step(2);

    // single requester, 2-cycle latency, exactly one pulse
    we_count = 0;
    load(0, 8'h41);
    step(8);
    chk("single_pulses", we_count, 1);
    load(0, 8'h0A);
    wait_idle("single_idle", 50);

    // contention: all four continuously valid
    ack_log.delete();
    for (int i = 0; i < NREQ; i++) begin
      load(i, 8'(i * 16));
      load(i, 8'(i * 16 + 1));
      load(i, 8'h0A);
    end
    wait_idle("contend_idle", 200);
    chk("contend_count", ack_log.size(), 12);
    for (int j = 0; j < 12 && j < ack_log.size(); j++) begin
`ifdef RS232_ARB_LINE_LOCK_EN
      k = (j / 3 + 1) % NREQ;
`else
      k = (j + 1) % NREQ;
`endif
      chk("contend_order", ack_log[j], k);
    end

    // backpressure: 17 bytes into a 16-deep FIFO while busy is held
    busy_mode = 1;
    step(2);
    for (int j = 0; j < 16; j++) load(0, 8'(8'h80 + j));
    load(0, 8'h0A);
    step(25);
    chk("bp_level", fifo_level, 16);
    chk("bp_pending", src_wr[0] - src_rd[0], 1);
    we_count = 0;
    busy_mode = 2;
    wait_idle("bp_idle", 600);
    chk("bp_pulses", we_count, 17);

    // busy handshake with mixed requesters
    for (int i = 0; i < NREQ; i++) begin
      load(i, 8'(8'hC0 + i));
      load(i, 8'h0A);
    end
    wait_idle("hs_idle", 300);

    // asynchronous reset with bytes queued and a pulse in flight
    busy_mode = 1;
    step(2);
    for (int j = 0; j < 4; j++) load(0, 8'(8'h50 + j));
    load(0, 8'h0A);
    step(8);
    chk("pre_rst_level5", fifo_level, 5);
    busy_mode = 2;
    k = 0;
    while (!tx_we && k < 10) begin
      step(1);
      k++;
    end
    chk("pre_rst_we", tx_we, 1);
    chk("pre_rst_level4", fifo_level, 4);
    #3 reset_n = 1'b0;
    #1;
    chk("async_we", tx_we, 0);
    chk("async_level", fifo_level, 0);
    chk("async_ack", req_ack, 0);
    step(2);
    clear_srcs();
    busy_mode = 0;
    @(negedge clk25MHz); #5 reset_n = 1'b1;
    step(2);

    // priority after reset: requester 0 first
    ack_log.delete();
    load(3, 8'h0A);
    load(0, 8'h0A);
    wait_idle("prio_idle", 50);
    chk("prio_count", ack_log.size(), 2);
    if (ack_log.size() == 2) begin
      chk("prio_first", ack_log[0], 0);
      chk("prio_second", ack_log[1], 3);
    end

    // line lock: "ab\n" from req 1 against req 2
    ack_log.delete();
    load(1, 8'h61); load(1, 8'h62); load(1, 8'h0A);
    load(2, 8'h78); load(2, 8'h0A);
    wait_idle("lock_idle", 100);
    chk("lock_count", ack_log.size(), 5);
    for (int j = 0; j < 5 && j < ack_log.size(); j++) begin
`ifdef RS232_ARB_LINE_LOCK_EN
      k = (j < 3) ? 1 : 2;
`else
      k = (j < 4) ? ((j % 2 == 0) ? 1 : 2) : 1;
`endif
      chk("lock_order", ack_log[j], k);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
